// File: rtl/fifo_mem_if.sv
// fifo_mem_if: push/pop handshake, data and status bundle for fifo_mem
interface fifo_mem_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic             write;
    logic [WIDTH-1:0] datain;
    logic             read;
    logic [WIDTH-1:0] dataout;
    logic             valid;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;
    modport master (
        output write, datain, read,
        input  dataout, valid, full, empty, count, overflow, underflow
    );
    modport slave (
        input  write, datain, read,
        output dataout, valid, full, empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH storage, synchronous write port, registered read port, no reset
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    // Write on accepted push; read register only loads on accepted pop so it holds otherwise
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_mem.sv
// fifo_mem: synchronous FIFO with registered pop data, flags and over/underflow pulses
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 7
) (
    input logic       clock,
    input logic       reset,
    fifo_mem_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [WIDTH-1:0]  rdata;
    logic              push, pop, cleared;

    function automatic logic [ADDR_W-1:0] inc(input logic [ADDR_W-1:0] p);
        return p == ADDR_W'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // A pop needs a stored word; a push into a full FIFO is allowed only alongside a pop
    assign pop  = !reset && bus.read && count != '0;
    assign push = !reset && bus.write && (count != CNT_W'(DEPTH) || pop);

    fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (bus.datain),
        .re    (pop),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    // Pointers, occupancy and one-cycle status pulses; cleared masks the unreset RAM read register
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            cleared       <= 1'b1;
            bus.valid     <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= inc(wr_ptr);
            if (pop) rd_ptr <= inc(rd_ptr);
            if (pop) cleared <= 1'b0;
            count         <= count + CNT_W'(push) - CNT_W'(pop);
            bus.valid     <= pop;
            bus.overflow  <= bus.write && !push;
            bus.underflow <= bus.read && !pop;
        end
    end

    assign bus.dataout = cleared ? '0 : rdata;
    assign bus.count   = count;
    assign bus.full    = count == CNT_W'(DEPTH);
    assign bus.empty   = count == '0;
endmodule

// File: tb/tb_fifo_mem.sv
// tb_fifo_mem: directed and random stimulus against a queue-based FIFO reference model
module tb_fifo_mem;
    localparam int W = 8;
    localparam int D = 7;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    fifo_mem_if #(.WIDTH(W), .DEPTH(D)) bus ();
    fifo_mem #(.WIDTH(W), .DEPTH(D)) dut (.clock(clock), .reset(reset), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout;
    bit           m_vld, m_ovf, m_unf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit w, input logic [W-1:0] d, input bit r, input bit rs = 1'b0);
        bit do_pop, do_push;
        bus.write  = w;
        bus.datain = d;
        bus.read   = r;
        reset      = rs;
        @(posedge clock);
        if (rs) begin
            q.delete();
            m_dout = '0;
            m_vld  = 1'b0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            do_pop  = r && q.size() > 0;
            do_push = w && (q.size() < D || do_pop);
            if (do_pop) m_dout = q.pop_front();
            if (do_push) q.push_back(d);
            m_vld = do_pop;
            m_ovf = w && !do_push;
            m_unf = r && !do_pop;
        end
        @(negedge clock);
        check("count", bus.count, q.size());
        check("full", bus.full, q.size() == D);
        check("empty", bus.empty, q.size() == 0);
        check("valid", bus.valid, m_vld);
        check("dataout", bus.dataout, m_dout);
        check("overflow", bus.overflow, m_ovf);
        check("underflow", bus.underflow, m_unf);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bus.write  = 1'b0;
        bus.datain = '0;
        bus.read   = 1'b0;
        reset      = 1'b1;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_dataout", bus.dataout, 0);

        step(1, 8'h00, 0);
        step(1, 8'h05, 0);
        step(1, 8'h08, 0);
        check("basic_count", bus.count, 3);
        step(0, 0, 1);
        check("basic_pop0", bus.dataout, 8'h00);
        step(0, 0, 1);
        check("basic_pop1", bus.dataout, 8'h05);
        step(0, 0, 1);
        check("basic_pop2", bus.dataout, 8'h08);
        check("basic_valid", bus.valid, 1);
        step(0, 0, 0);
        check("basic_empty", bus.empty, 1);
        check("basic_valid_drop", bus.valid, 0);

        for (int i = 0; i < D; i++) step(1, W'(8'h10 + i), 0);
        check("fill_full", bus.full, 1);
        check("fill_count", bus.count, 7);
        step(1, 8'h40, 0);
        check("ovf_pulse", bus.overflow, 1);
        check("ovf_count", bus.count, 7);
        step(0, 0, 0);
        check("ovf_drop", bus.overflow, 0);
        for (int i = 0; i < D; i++) begin
            step(0, 0, 1);
            check("fill_pop", bus.dataout, W'(8'h10 + i));
        end

        step(0, 0, 1);
        check("unf_pulse", bus.underflow, 1);
        check("unf_valid", bus.valid, 0);
        check("unf_hold", bus.dataout, 8'h16);
        step(1, 8'h70, 1);
        check("wr_rd_empty_unf", bus.underflow, 1);
        check("wr_rd_empty_count", bus.count, 1);

        for (int i = 1; i < D; i++) step(1, W'(8'h70 + i), 0);
        check("full_again", bus.full, 1);
        step(1, 8'h04, 1);
        check("full_wr_rd_ovf", bus.overflow, 0);
        check("full_wr_rd_count", bus.count, 7);
        check("full_wr_rd_out", bus.dataout, 8'h70);
        for (int i = 0; i < D; i++) step(0, 0, 1);
        check("full_wr_rd_last", bus.dataout, 8'h04);

        for (int i = 0; i < 20; i++) begin
            step(1, W'($urandom), 0);
            if ($urandom_range(0, 1) == 1) step(0, 0, 0);
            step(0, 0, 1);
            if ($urandom_range(0, 1) == 1) step(0, 0, 0);
        end

        for (int i = 0; i < 4; i++) step(1, W'(8'h50 + i), 0);
        step(1, 8'h99, 0, 1);
        check("midrst_count", bus.count, 0);
        check("midrst_empty", bus.empty, 1);
        check("midrst_valid", bus.valid, 0);
        check("midrst_dataout", bus.dataout, 0);
        step(1, 8'h04, 0);
        step(0, 0, 1);
        check("midrst_pop", bus.dataout, 8'h04);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 2) != 0, W'($urandom), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 60) == 0);
            check("count_bound", bus.count <= D, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
